// File: rtl/neuron_accum_ctrl_pkg.sv
// Shared definitions for the unary (thermometer-coded) neuron accumulator controller.
// Holds the FSM state type, operand/total widths and sign-bit positions.
package neuron_accum_ctrl_pkg;

  // Term operand: sign bit plus 16-bit thermometer magnitude.
  localparam int unsigned IN_W     = 17;
  localparam int unsigned MAG_IN   = 16;
  localparam int unsigned SIGN_IN  = 16;

  // Running total: sign bit plus 32-bit thermometer magnitude.
  localparam int unsigned TOT_W    = 33;
  localparam int unsigned MAG_TOT  = 32;
  localparam int unsigned SIGN_TOT = 32;

  // Ones-count widths for each magnitude field; the sum needs one more bit.
  localparam int unsigned POP_IN_W  = $clog2(MAG_IN + 1);
  localparam int unsigned POP_TOT_W = $clog2(MAG_TOT + 1);
  localparam int unsigned POP_SUM_W = POP_TOT_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StCapture,
    StDone
  } state_e;

endpackage

// File: rtl/therm_popcount.sv
// Combinational ones-counter of parameterised width.
//   vec_i   : input vector (thermometer magnitude)
//   count_o : number of set bits in vec_i
module therm_popcount #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0]           vec_i,
  output logic [$clog2(Width+1)-1:0] count_o
);

  localparam int unsigned CountW = $clog2(Width + 1);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      count_o = count_o + CountW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/neuron_accum_ctrl.sv
// Sequencing controller for accumulating signed thermometer-coded terms through an
// external registered unary adder.
//   clk_i / rst_i          : clock, synchronous active-high reset
//   start_i, num_terms_i   : begin an accumulation of num_terms_i terms (IDLE only)
//   term_valid_i/_data_i   : incoming term stream; term_ready_o accepts it (FETCH only)
//   add_in_o, add_total_o  : registered operands presented to the external adder
//   add_out_i              : adder result, valid ADD_LAT cycles after the operands
//   result_o/_valid_o      : final total, held until result_ready_i
//   busy_o                 : controller not idle
//   ovf_o                  : sticky magnitude-capacity overflow for this accumulation
module neuron_accum_ctrl
  import neuron_accum_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned ADD_LAT   = 1,
  localparam int unsigned CntW     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CntW-1:0]  num_terms_i,
  input  logic             term_valid_i,
  input  logic [IN_W-1:0]  term_data_i,
  output logic             term_ready_o,
  output logic [IN_W-1:0]  add_in_o,
  output logic [TOT_W-1:0] add_total_o,
  input  logic [TOT_W-1:0] add_out_i,
  output logic [TOT_W-1:0] result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int unsigned LatW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  state_e           state_q, state_d;
  logic [TOT_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]  add_in_q, add_in_d;
  logic [TOT_W-1:0] add_total_q, add_total_d;
  logic [CntW-1:0]  terms_q, terms_d;
  logic [LatW-1:0]  wait_q, wait_d;
  logic             ovf_q, ovf_d;

  logic [POP_IN_W-1:0]  pop_in;
  logic [POP_TOT_W-1:0] pop_tot;
  logic [POP_SUM_W-1:0] pop_sum;
  logic                 ovf_hit;

  therm_popcount #(
    .Width (MAG_IN)
  ) u_pop_in (
    .vec_i   (term_data_i[MAG_IN-1:0]),
    .count_o (pop_in)
  );

  therm_popcount #(
    .Width (MAG_TOT)
  ) u_pop_tot (
    .vec_i   (acc_q[MAG_TOT-1:0]),
    .count_o (pop_tot)
  );

  // Same-sign addition whose ones would not fit in the total's magnitude field.
  assign pop_sum = POP_SUM_W'(pop_in) + POP_SUM_W'(pop_tot);
  assign ovf_hit = (term_data_i[SIGN_IN] == acc_q[SIGN_TOT]) &&
                   (pop_sum > POP_SUM_W'(MAG_TOT));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    add_in_d    = add_in_q;
    add_total_d = add_total_q;
    terms_d     = terms_q;
    wait_d      = wait_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          terms_d = num_terms_i;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (num_terms_i == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (term_valid_i) begin
          add_in_d    = term_data_i;
          add_total_d = acc_q;
          wait_d      = LatW'(ADD_LAT - 1);
          if (ovf_hit) begin
            ovf_d = 1'b1;
          end
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == '0) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StCapture: begin
        acc_d   = add_out_i;
        terms_d = terms_q - 1'b1;
        state_d = (terms_q == CntW'(1)) ? StDone : StFetch;
      end
      StDone: begin
        if (result_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      add_in_q    <= '0;
      add_total_q <= '0;
      terms_q     <= '0;
      wait_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      add_in_q    <= add_in_d;
      add_total_q <= add_total_d;
      terms_q     <= terms_d;
      wait_q      <= wait_d;
      ovf_q       <= ovf_d;
    end
  end

  assign term_ready_o   = (state_q == StFetch);
  assign result_valid_o = (state_q == StDone);
  assign busy_o         = (state_q != StIdle);
  assign result_o       = acc_q;
  assign add_in_o       = add_in_q;
  assign add_total_o    = add_total_q;
  assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_neuron_accum_ctrl.sv
module tb_neuron_accum_ctrl;

  localparam int MaxTerms = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_terms = '0;
  logic        term_valid = 1'b0;
  logic [16:0] term_data = '0;
  logic        term_ready;
  logic [16:0] add_in;
  logic [32:0] add_total;
  logic [32:0] add_out = '0;
  logic [32:0] result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model of the accumulation: signed integer magnitude.
  bit m_sign;
  int m_mag;
  bit m_ovf;

  logic [16:0] terms [MaxTerms];
  int          gaps  [MaxTerms];

  always #5 clk = ~clk;

  neuron_accum_ctrl #(
    .MAX_TERMS (8),
    .ADD_LAT   (1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .num_terms_i    (num_terms),
    .term_valid_i   (term_valid),
    .term_data_i    (term_data),
    .term_ready_o   (term_ready),
    .add_in_o       (add_in),
    .add_total_o    (add_total),
    .add_out_i      (add_out),
    .result_o       (result),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .busy_o         (busy),
    .ovf_o          (ovf)
  );

  function automatic logic [31:0] therm32(input int m);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    if (m <= 0) return 32'h0;
    return ones >> (32 - m);
  endfunction

  function automatic logic [16:0] mk_term(input bit s, input int m);
    logic [15:0] ones;
    ones = 16'hFFFF;
    if (m <= 0) return {s, 16'h0};
    return {s, ones >> (16 - m)};
  endfunction

  // Ideal external unary adder with one register stage, saturating at 32 ones.
  function automatic logic [32:0] ideal_add(input logic [16:0] a, input logic [32:0] t);
    int pa, pt;
    pa = $countones(a[15:0]);
    pt = $countones(t[31:0]);
    if (a[16] == t[32]) return {t[32], therm32((pa + pt > 32) ? 32 : pa + pt)};
    if (pa > pt) return {a[16], therm32(pa - pt)};
    if (pt > pa) return {t[32], therm32(pt - pa)};
    return 33'h0;
  endfunction

  always @(posedge clk) add_out <= ideal_add(add_in, add_total);

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fold one accepted term into the reference model.
  task automatic model_term(input logic [16:0] t);
    int pa;
    bit s;
    pa = $countones(t[15:0]);
    s  = t[16];
    if (s == m_sign && pa + m_mag > 32) m_ovf = 1'b1;
    if (s == m_sign) m_mag = (m_mag + pa > 32) ? 32 : m_mag + pa;
    else if (pa > m_mag) begin
      m_sign = s;
      m_mag  = pa - m_mag;
    end else if (m_mag > pa) m_mag = m_mag - pa;
    else begin
      m_sign = 1'b0;
      m_mag  = 0;
    end
  endtask

  // One full accumulation using terms[] and gaps[]; poke pulses start while busy.
  task automatic run_job(input int n, input int rdy_delay, input bit poke);
    int          t0, lat_exp;
    logic [16:0] hold_in;
    logic [32:0] hold_res;
    logic [32:0] exp_total;
    m_sign  = 1'b0;
    m_mag   = 0;
    m_ovf   = 1'b0;
    lat_exp = 1;
    t0      = cyc;
    start = 1'b1;
    num_terms = 4'(n);
    step();
    start = 1'b0;
    num_terms = 4'($urandom_range(0, 8));
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 10 && !term_ready; w++) step();
      chk("term_ready_fetch", {63'b0, term_ready}, 64'd1);
      hold_in = add_in;
      for (int g = 0; g < gaps[k]; g++) begin
        if (poke) begin
          start = 1'b1;
          num_terms = 4'(MaxTerms);
        end
        step();
        start = 1'b0;
        chk("fetch_hold_ready", {63'b0, term_ready}, 64'd1);
        chk("fetch_hold_add_in", {47'b0, add_in}, {47'b0, hold_in});
      end
      lat_exp += 3 + gaps[k];
      exp_total = {m_sign, therm32(m_mag)};
      term_valid = 1'b1;
      term_data  = terms[k];
      step();
      term_valid = 1'b0;
      term_data  = 17'($urandom);
      model_term(terms[k]);
      chk("add_in", {47'b0, add_in}, {47'b0, terms[k]});
      chk("add_total", {31'b0, add_total}, {31'b0, exp_total});
      chk("ovf_after_hs", {63'b0, ovf}, {63'b0, m_ovf});
      chk("ready_low_wait", {63'b0, term_ready}, 64'd0);
    end
    for (int w = 0; w < 12 && !result_valid; w++) step();
    chk("latency", 64'(cyc - t0), 64'(lat_exp));
    chk("result_valid", {63'b0, result_valid}, 64'd1);
    chk("result", {31'b0, result}, {31'b0, m_sign, therm32(m_mag)});
    chk("ovf_done", {63'b0, ovf}, {63'b0, m_ovf});
    chk("ready_low_done", {63'b0, term_ready}, 64'd0);
    hold_res = result;
    for (int d = 0; d < rdy_delay; d++) begin
      if (poke) begin
        start = 1'b1;
        num_terms = 4'(0);
      end
      step();
      start = 1'b0;
      chk("done_hold_valid", {63'b0, result_valid}, 64'd1);
      chk("done_hold_result", {31'b0, result}, {31'b0, hold_res});
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("valid_drop", {63'b0, result_valid}, 64'd0);
    chk("idle_busy", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_valid", {63'b0, result_valid}, 64'd0);
    chk("rst_ready", {63'b0, term_ready}, 64'd0);
    chk("rst_ovf", {63'b0, ovf}, 64'd0);
    chk("rst_result", {31'b0, result}, 64'd0);
    chk("rst_add_in", {47'b0, add_in}, 64'd0);
    chk("rst_add_total", {31'b0, add_total}, 64'd0);

    // Two-term sum: 3 + 2 ones -> 5 ones, 7 cycles.
    terms[0] = 17'h00007;
    terms[1] = 17'h00003;
    gaps[0] = 0;
    gaps[1] = 0;
    run_job(2, 0, 1'b0);
    chk("sum_const", {31'b0, result}, 64'h1F);
    chk("sum_ovf", {63'b0, ovf}, 64'd0);

    // Zero term count.
    run_job(0, 0, 1'b0);
    chk("zero_result", {31'b0, result}, 64'd0);

    // Overflow: 16 + 14 ones, then 16 more.
    terms[0] = 17'h0FFFF;
    terms[1] = 17'h03FFF;
    terms[2] = 17'h0FFFF;
    gaps[0] = 0;
    gaps[1] = 0;
    gaps[2] = 0;
    run_job(3, 0, 1'b0);
    chk("ovf_const", {63'b0, ovf}, 64'd1);

    // Backpressure, result hold and start ignored while busy.
    terms[0] = mk_term(1'b0, 9);
    terms[1] = mk_term(1'b1, 0);
    terms[2] = mk_term(1'b1, 4);
    gaps[0] = 5;
    gaps[1] = 2;
    gaps[2] = 0;
    run_job(3, 4, 1'b1);
    chk("bp_result_const", {31'b0, result}, {31'b0, 33'h00000001F});

    // Reset during WAIT of term 2 of 3.
    start = 1'b1;
    num_terms = 4'd3;
    step();
    start = 1'b0;
    term_valid = 1'b1;
    term_data = 17'h0FFFF;
    step();
    term_valid = 1'b0;
    step();
    step();
    term_valid = 1'b1;
    term_data = 17'h0001F;
    step();
    term_valid = 1'b0;
    chk("mid_add_total", {31'b0, add_total}, 64'h0FFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_valid", {63'b0, result_valid}, 64'd0);
    chk("midrst_ovf", {63'b0, ovf}, 64'd0);
    chk("midrst_add_total", {31'b0, add_total}, 64'd0);
    chk("midrst_add_in", {47'b0, add_in}, 64'd0);

    // Reset beats a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    num_terms = 4'd0;
    step();
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("rst_start_busy", {63'b0, busy}, 64'd0);
    chk("rst_start_valid", {63'b0, result_valid}, 64'd0);

    // Fresh job after reset.
    terms[0] = mk_term(1'b0, 12);
    gaps[0] = 0;
    run_job(1, 1, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      int n;
      n = $urandom_range(0, MaxTerms);
      for (int k = 0; k < MaxTerms; k++) begin
        terms[k] = mk_term(($urandom_range(0, 3) == 0), $urandom_range(0, 16));
        gaps[k]  = $urandom_range(0, 2);
      end
      run_job(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_accum_ctrl.md
NEURON_ACCUM_CTRL -- requirements
Module: neuron_accum_ctrl

Interface
REQ-001 Parameter MAX_TERMS, 8, maximum number of terms per accumulation; num_terms width is clog2(MAX_TERMS+1).
REQ-002 Parameter ADD_LAT, 1, registered latency of the external unary adder, in cycles.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin an accumulation; sampled only in IDLE.
REQ-006 num_terms  input  clog2(MAX_TERMS+1)  term count; latched on start.
REQ-007 term_valid  input  1  term_data is valid.
REQ-008 term_data  input  17  sign bit [16] plus 16-bit thermometer magnitude [15:0].
REQ-009 term_ready  output  1  controller accepts term_data this cycle.
REQ-010 add_in  output  17  registered operand to the adder's in port.
REQ-011 add_total  output  33  registered running total to the adder's total port.
REQ-012 add_out  input  33  adder result: sign bit [32] plus 32-bit thermometer magnitude [31:0].
REQ-013 result  output  33  final accumulated value.
REQ-014 result_valid  output  1  result is valid; held until result_ready.
REQ-015 result_ready  input  1  consumer takes the result.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 ovf  output  1  sticky flag: magnitude capacity exceeded during this accumulation.

Function
REQ-018 The FSM SHALL use the states IDLE, FETCH, WAIT, CAPTURE and DONE.
REQ-019 IDLE: when start=1 it SHALL latch num_terms, clear acc to 33'b0 and clear ovf. It goes to DONE if num_terms=0, otherwise to FETCH.
REQ-020 FETCH: term_ready SHALL be 1. On term_valid&term_ready it registers add_in=term_data and add_total=acc, then goes to WAIT.
REQ-021 FETCH with term_valid=0 SHALL hold the state; add_in and add_total stay unchanged.
REQ-022 WAIT SHALL last exactly ADD_LAT cycles, counted by a down-counter; it then goes to CAPTURE.
REQ-023 CAPTURE SHALL load acc from add_out and decrement the remaining-term count. It goes to DONE if the count reaches 0, otherwise to FETCH.
REQ-024 Per-term throughput SHALL be 2+ADD_LAT cycles with no backpressure, i.e. 3 cycles at the default.
REQ-025 DONE: result SHALL equal acc and result_valid SHALL be 1. On result_ready the FSM returns to IDLE; result_valid deasserts in the following cycle.
REQ-026 On every handshake, ovf SHALL set when term_data[16]==acc[32] and popcount(term_data[15:0])+popcount(acc[31:0]) > 32. The term is still forwarded; ovf stays set until the next start.
REQ-027 start asserted outside IDLE SHALL be ignored.
REQ-028 term_ready SHALL be 0 in all states other than FETCH.
REQ-029 A term of zero magnitude SHALL be accepted and processed like any other term.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-WAIT. All of the following clear to 0: acc, add_in, add_total, result, result_valid, term_ready, busy, ovf, the term counter and the WAIT counter.
REQ-031 When rst=1 and start=1 in the same cycle, rst SHALL win and start is not latched.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the width constants IN_W=17, TOT_W=33 and MAG_IN=16, MAG_TOT=32, and the sign-bit indices.
REQ-033 There SHALL be one sub-module, therm_popcount: a parameterised-width combinational ones-counter, instantiated twice for the ovf check.
REQ-034 The adder SHALL stay outside this block; connect it via add_in, add_total and add_out.

Verification
REQ-035 Sum: num_terms=2, terms 17'h00007 then 17'h00003, ideal adder. Required: result=33'h00000001F, ovf=0, result_valid 7 cycles after start.
REQ-036 Zero count: num_terms=0, start pulse. Required: result=0 and result_valid=1 one cycle after the IDLE start edge; no term_ready pulse.
REQ-037 Overflow: acc=+30 ones, then term 17'h0FFFF. Required: ovf=1 after that handshake and still 1 in DONE.
REQ-038 Backpressure and result hold: term_valid low for 5 cycles in FETCH, result_ready low for 4 cycles in DONE. Required: FETCH held and add_in stable throughout; result and result_valid stable until result_ready.
REQ-039 Reset mid-operation: rst pulse during WAIT of term 2 of 3. Required: next cycle busy=0, result_valid=0, ovf=0, add_total=0; a fresh start then completes normally.
REQ-040 Start ignored: start pulsed during FETCH and during DONE. Required: num_terms and acc unaffected.
